// File: rtl/loopback_test_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : loopback_test_seq_if
//  Purpose  : Handshake/pin bundle between the loopback sequencer and its host.
//  Revision : 1.0 - initial release
// ============================================================================
interface loopback_test_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] rcv;
    logic [WIDTH-1:0] drv;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       err_cnt;
    logic [WIDTH-1:0] fail_bit;

    modport master (
        output start, rcv,
        input  drv, busy, done, pass, err_cnt, fail_bit
    );

    modport slave (
        input  start, rcv,
        output drv, busy, done, pass, err_cnt, fail_bit
    );
endinterface
`default_nettype wire

// File: rtl/loopback_test_seq.sv
`default_nettype none
// ============================================================================
//  Module   : loopback_test_seq
//  Purpose  : Walks a fixed vector set over the board loopback pins and
//             reports mismatching vectors and bit positions.
//  Revision : 1.0 - initial release
// ============================================================================
module loopback_test_seq #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4,
    parameter int INVERT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    loopback_test_seq_if.slave      bus
);

    localparam int NV = 2 * WIDTH + 2;
    localparam int VW = $clog2(NV);
    localparam int CW = $clog2(SETTLE);

    localparam logic [VW-1:0] C_LAST_V   = VW'(NV - 1);
    localparam logic [VW-1:0] C_W_V      = VW'(WIDTH);
    localparam logic [VW-1:0] C_W2_V     = VW'(2 * WIDTH);
    localparam logic [CW-1:0] C_CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [VW-1:0]    v_q,        v_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] drv_q,      drv_d;
    logic [7:0]       err_q,      err_d;
    logic [WIDTH-1:0] fail_q,     fail_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             pass_q,     pass_d;
    logic [WIDTH-1:0] rcv_s1_q;
    logic [WIDTH-1:0] rcv_s_q;

    logic [WIDTH-1:0] w_exp;
    logic [WIDTH-1:0] w_mismatch;

    function automatic logic [WIDTH-1:0] vec_of(input logic [VW-1:0] v);
        logic [WIDTH-1:0] one;
        one = WIDTH'(1);
        if (v < C_W_V)
            vec_of = one << v;
        else if (v < C_W2_V)
            vec_of = ~(one << (v - C_W_V));
        else if (v == C_W2_V)
            vec_of = '0;
        else
            vec_of = '1;
    endfunction

    assign w_exp      = (INVERT != 0) ? ~drv_q : drv_q;
    assign w_mismatch = rcv_s_q ^ w_exp;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        err_d   = err_q;
        fail_d  = fail_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    v_d     = '0;
                    drv_d   = vec_of('0);
                    cnt_d   = C_CNT_INIT;
                    err_d   = '0;
                    fail_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0)
                    state_d = ST_CHECK;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            ST_CHECK: begin
                // Count vectors, not bits; the counter pins at 255.
                if (w_mismatch != '0) begin
                    if (err_q != 8'hFF)
                        err_d = err_q + 8'd1;
                    fail_d = fail_q | w_mismatch;
                end
                if (v_q == C_LAST_V) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'd0);
                    state_d = ST_DONE;
                end else begin
                    v_d     = v_q + 1'b1;
                    drv_d   = vec_of(v_q + 1'b1);
                    cnt_d   = C_CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            v_q      <= '0;
            cnt_q    <= '0;
            drv_q    <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            rcv_s1_q <= '0;
            rcv_s_q  <= '0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            rcv_s1_q <= bus.rcv;
            rcv_s_q  <= rcv_s1_q;
        end
    end

    assign bus.drv      = drv_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_bit = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_loopback_test_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loopback_test_seq
//  Purpose  : Scoreboard bench for the loopback sequencer, 8-bit and 128-bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_loopback_test_seq;

    localparam int LAT_A = (2 * 8 + 2) * 5;
    localparam int LAT_B = (2 * 128 + 2) * 5;

    typedef struct {
        int           err;
        logic [127:0] fb;
        bit           pass;
        int           c0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;

    exp_t qa[$];
    exp_t qb[$];

    logic [7:0]   xa = 8'hFF, s0a = 8'h00, s1a = 8'h00;
    logic [127:0] xb = '0,    s0b = '0,    s1b = '0;

    loopback_test_seq_if #(.WIDTH(8))   ifa ();
    loopback_test_seq_if #(.WIDTH(128)) ifb ();

    // Board model: optional inverter (x), then stuck-at-0 / stuck-at-1 faults.
    assign ifa.rcv = ((ifa.drv ^ xa) & ~s0a) | s1a;
    assign ifb.rcv = ((ifb.drv ^ xb) & ~s0b) | s1b;

    loopback_test_seq #(.WIDTH(8), .SETTLE(4), .INVERT(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    loopback_test_seq #(.WIDTH(128), .SETTLE(4), .INVERT(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] vec_of(input int w, input int v);
        logic [127:0] all;
        logic [127:0] one;
        one = 128'd1;
        all = (w == 128) ? '1 : ((one << w) - one);
        if (v < w)          return one << v;
        else if (v < 2 * w) return all & ~(one << (v - w));
        else if (v == 2 * w) return '0;
        else                return all;
    endfunction

    function automatic exp_t model(input int w, input bit inv, input logic [127:0] x,
                                   input logic [127:0] s0, input logic [127:0] s1);
        exp_t e;
        logic [127:0] all, d, r, ex, m;
        all = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        e.err = 0;
        e.fb  = '0;
        e.c0  = 0;
        for (int v = 0; v < 2 * w + 2; v++) begin
            d  = vec_of(w, v);
            r  = (((d ^ x) & ~s0) | s1) & all;
            ex = inv ? (~d & all) : d;
            m  = r ^ ex;
            if (m != '0) begin
                e.err = (e.err >= 255) ? 255 : e.err + 1;
                e.fb  = e.fb | m;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    initial begin : mon_a
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.done && !prev) begin
                if (qa.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL a_unexpected_done: got done=1, expected no completion");
                end else begin
                    e = qa.pop_front();
                    check("a_err_cnt",  ifa.err_cnt,  e.err);
                    check("a_fail_bit", ifa.fail_bit, e.fb);
                    check("a_pass",     ifa.pass,     e.pass);
                    check("a_latency",  cyc - e.c0,   LAT_A);
                end
            end
            prev = ifa.done;
        end
    end

    initial begin : mon_b
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ifb.done && !prev) begin
                if (qb.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL b_unexpected_done: got done=1, expected no completion");
                end else begin
                    e = qb.pop_front();
                    check("b_err_cnt",  ifb.err_cnt,  e.err);
                    check("b_fail_bit", ifb.fail_bit, e.fb);
                    check("b_pass",     ifb.pass,     e.pass);
                    check("b_latency",  cyc - e.c0,   LAT_B);
                end
            end
            prev = ifb.done;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_a_drv"},  ifa.drv,      0);
        check({tag, "_a_busy"}, ifa.busy,     0);
        check({tag, "_a_done"}, ifa.done,     0);
        check({tag, "_a_pass"}, ifa.pass,     0);
        check({tag, "_a_err"},  ifa.err_cnt,  0);
        check({tag, "_a_fail"}, ifa.fail_bit, 0);
        check({tag, "_b_drv"},  ifb.drv,      0);
        check({tag, "_b_busy"}, ifb.busy,     0);
        check({tag, "_b_done"}, ifb.done,     0);
    endtask

    task automatic wait_empty_a();
        int n = 0;
        while (qa.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (qa.size() != 0) begin
            n_vec++; n_mis++;
            $display("FAIL a_timeout: got no done after %0d cycles, expected done", n);
            qa.delete();
        end
    endtask

    task automatic wait_empty_b();
        int n = 0;
        while (qb.size() != 0 && n < 1600) begin
            @(negedge clk);
            n++;
        end
        if (qb.size() != 0) begin
            n_vec++; n_mis++;
            $display("FAIL b_timeout: got no done after %0d cycles, expected done", n);
            qb.delete();
        end
    endtask

    // Full run on the 8-bit instance, also tracking the drive sequence.
    task automatic run_a(input logic [7:0] x, input logic [7:0] s0, input logic [7:0] s1);
        exp_t e;
        @(negedge clk);
        xa = x; s0a = s0; s1a = s1;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        e    = model(8, 1'b1, {120'd0, x}, {120'd0, s0}, {120'd0, s1});
        e.c0 = cyc;
        qa.push_back(e);
        for (int v = 0; v < 18; v++) begin
            check("a_drv_step", ifa.drv, vec_of(8, v));
            check("a_busy_run", ifa.busy, 1);
            check("a_pass_run", ifa.pass, 0);
            repeat (5) @(negedge clk);
        end
        wait_empty_a();
    endtask

    task automatic run_b(input logic [127:0] x, input logic [127:0] s0, input logic [127:0] s1);
        exp_t e;
        @(negedge clk);
        xb = x; s0b = s0; s1b = s1;
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        e    = model(128, 1'b0, x, s0, s1);
        e.c0 = cyc;
        qb.push_back(e);
        wait_empty_b();
    endtask

    function automatic logic [127:0] sparse128();
        logic [127:0] a, b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        return a & b & {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        int   c0;
        int   n;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean inverter, one stuck-at-0 bit, then a straight wire.
        run_a(8'hFF, 8'h00, 8'h00);
        run_a(8'hFF, 8'h08, 8'h00);
        run_a(8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 8; i++)
            run_a(8'hFF ^ 8'($urandom & $urandom & $urandom),
                  8'($urandom & $urandom & $urandom),
                  8'($urandom & $urandom & $urandom));

        // Reset 40 cycles into a run: everything clears, no completion follows.
        @(negedge clk);
        xa = 8'hF0; s0a = 8'h00; s1a = 8'h00;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks("midrun");
        @(negedge clk);
        rst = 1'b0;
        run_a(8'hFF, 8'h00, 8'h00);

        // Start pulses during a run are ignored.
        @(negedge clk);
        xa = 8'hFF; s0a = 8'h00; s1a = 8'h80;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        e    = model(8, 1'b1, 128'hFF, 128'h0, 128'h80);
        e.c0 = cyc;
        qa.push_back(e);
        repeat (9) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (39) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_empty_a();

        // Start held high: the next run begins the cycle after DONE is entered.
        @(negedge clk);
        xa = 8'hFF; s0a = 8'h00; s1a = 8'h00;
        ifa.start = 1'b1;
        @(negedge clk);
        c0   = cyc;
        e    = model(8, 1'b1, 128'hFF, 128'h0, 128'h0);
        e.c0 = c0;
        qa.push_back(e);
        n = 0;
        while (!ifa.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("held_done_seen", ifa.done, 1);
        e.c0 = c0 + LAT_A + 1;
        qa.push_back(e);
        @(negedge clk);
        ifa.start = 1'b0;
        check("held_restart_done", ifa.done, 0);
        check("held_restart_busy", ifa.busy, 1);
        check("held_restart_drv",  ifa.drv,  vec_of(8, 0));
        wait_empty_a();

        // Wide instance: straight wire passes, inverted wire saturates the count.
        run_b('0, '0, '0);
        run_b('1, '0, '0);
        run_b(sparse128(), sparse128(), sparse128());

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
